// File: rtl/io_bridge_pkg.sv
// Shared definitions for the AXI4-Lite UART I/O bridge.
// UART-Lite register offsets, STAT bit positions, AXI response code, FSM states.
package io_bridge_pkg;

    localparam logic [31:0] UART_RX_OFS   = 32'h0000_0000;
    localparam logic [31:0] UART_TX_OFS   = 32'h0000_0004;
    localparam logic [31:0] UART_STAT_OFS = 32'h0000_0008;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR_STAT,
        ST_R_STAT,
        ST_AR_RX,
        ST_R_RX,
        ST_W_TX,
        ST_B_WAIT
    } state_e;

    function automatic logic resp_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
// Ports: i_clk, i_rstn (sync, active-low), i_push/i_wdata, i_pop/o_rdata,
//        o_full, o_empty, o_count. Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/axil_uart_io_bridge.sv
// Bridges core byte/word output and byte input to an AXI4-Lite UART-Lite.
// Ports: i_clk, i_rstn; core side i_out_req/i_out_data/o_out_busy,
//        i_in_req/o_in_data/o_in_valid/o_rx_count, o_axi_err; AXI4-Lite master.
module axil_uart_io_bridge
    import io_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          TX_DEPTH      = 16,
    parameter int          RX_DEPTH      = 16,
    parameter int          OUT_BYTES     = 1,
    parameter int          POLL_INTERVAL = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_out_req,
    input  logic [31:0]                 i_out_data,
    output logic                        o_out_busy,
    input  logic                        i_in_req,
    output logic [7:0]                  o_in_data,
    output logic                        o_in_valid,
    output logic [$clog2(RX_DEPTH):0]   o_rx_count,
    output logic                        o_axi_err,
    output logic [31:0]                 o_axi_awaddr,
    output logic [2:0]                  o_axi_awprot,
    output logic                        o_axi_awvalid,
    input  logic                        i_axi_awready,
    output logic [31:0]                 o_axi_wdata,
    output logic [3:0]                  o_axi_wstrb,
    output logic                        o_axi_wvalid,
    input  logic                        i_axi_wready,
    input  logic [1:0]                  i_axi_bresp,
    input  logic                        i_axi_bvalid,
    output logic                        o_axi_bready,
    output logic [31:0]                 o_axi_araddr,
    output logic [2:0]                  o_axi_arprot,
    output logic                        o_axi_arvalid,
    input  logic                        i_axi_arready,
    input  logic [31:0]                 i_axi_rdata,
    input  logic [1:0]                  i_axi_rresp,
    input  logic                        i_axi_rvalid,
    output logic                        o_axi_rready
);

    localparam int TW = $clog2(POLL_INTERVAL + 1);
    localparam logic [1:0] LAST_BYTE = 2'(OUT_BYTES - 1);

    state_e       r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]   r_byte_idx;
    logic         r_arvalid;
    logic [31:0]  r_araddr;
    logic         r_rready;
    logic         r_awvalid;
    logic [31:0]  r_awaddr;
    logic         r_wvalid;
    logic [31:0]  r_wdata;
    logic         r_bready;
    logic         r_err;

    logic [31:0]  w_tx_word;
    logic [7:0]   w_tx_byte;
    logic         w_tx_full;
    logic         w_tx_empty;
    logic         w_tx_pop;
    logic [$clog2(TX_DEPTH):0] w_tx_count_unused;

    logic         w_rx_full;
    logic         w_rx_empty;
    logic         w_rx_push;

    logic         w_aw_done;
    logic         w_w_done;
    logic         w_unused;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (i_out_req),
        .i_wdata (i_out_data),
        .i_pop   (w_tx_pop),
        .o_rdata (w_tx_word),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count_unused)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (w_rx_push),
        .i_wdata (i_axi_rdata[7:0]),
        .i_pop   (i_in_req),
        .o_rdata (o_in_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (o_rx_count)
    );

    // Bytes of the head word leave LSB first.
    assign w_tx_byte = w_tx_word[{r_byte_idx, 3'b000} +: 8];

    // The word leaves the FIFO only once its last byte is acknowledged.
    assign w_tx_pop  = (r_state == ST_B_WAIT) && i_axi_bvalid
                       && (r_byte_idx == LAST_BYTE);
    assign w_rx_push = (r_state == ST_R_RX) && i_axi_rvalid;

    // AW and W complete independently; a channel is done once its valid drops.
    assign w_aw_done = !r_awvalid || i_axi_awready;
    assign w_w_done  = !r_wvalid || i_axi_wready;

    assign w_unused  = &{1'b0, i_axi_rdata[31:8], w_tx_count_unused};

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_byte_idx <= '0;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_rready   <= 1'b0;
            r_awvalid  <= 1'b0;
            r_awaddr   <= '0;
            r_wvalid   <= 1'b0;
            r_wdata    <= '0;
            r_bready   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_tx_empty || r_timer == TW'(POLL_INTERVAL - 1)) begin
                        r_state   <= ST_AR_STAT;
                        r_arvalid <= 1'b1;
                        r_araddr  <= BASE_ADDR + UART_STAT_OFS;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_AR_STAT: begin
                    if (i_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R_STAT;
                    end
                end
                ST_R_STAT: begin
                    if (i_axi_rvalid) begin
                        r_rready <= 1'b0;
                        if (resp_err(i_axi_rresp)) begin
                            r_err <= 1'b1;
                        end
                        // RX wins so incoming bytes are drained first; a full
                        // RX buffer leaves the byte waiting in the UART.
                        if (i_axi_rdata[STAT_RX_VALID] && !w_rx_full) begin
                            r_state   <= ST_AR_RX;
                            r_arvalid <= 1'b1;
                            r_araddr  <= BASE_ADDR + UART_RX_OFS;
                        end else if (!i_axi_rdata[STAT_TX_FULL] && !w_tx_empty) begin
                            r_state   <= ST_W_TX;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_awaddr  <= BASE_ADDR + UART_TX_OFS;
                            r_wdata   <= {24'b0, w_tx_byte};
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_AR_RX: begin
                    if (i_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R_RX;
                    end
                end
                ST_R_RX: begin
                    if (i_axi_rvalid) begin
                        r_rready <= 1'b0;
                        if (resp_err(i_axi_rresp)) begin
                            r_err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                ST_W_TX: begin
                    if (i_axi_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (i_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_B_WAIT;
                    end
                end
                ST_B_WAIT: begin
                    if (i_axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (resp_err(i_axi_bresp)) begin
                            r_err <= 1'b1;
                        end
                        if (r_byte_idx == LAST_BYTE) begin
                            r_byte_idx <= '0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_out_busy    = w_tx_full;
    assign o_in_valid    = !w_rx_empty;
    assign o_axi_err     = r_err;

    assign o_axi_awaddr  = r_awaddr;
    assign o_axi_awprot  = 3'b000;
    assign o_axi_awvalid = r_awvalid;
    assign o_axi_wdata   = r_wdata;
    assign o_axi_wstrb   = 4'b0001;
    assign o_axi_wvalid  = r_wvalid;
    assign o_axi_bready  = r_bready;
    assign o_axi_araddr  = r_araddr;
    assign o_axi_arprot  = 3'b000;
    assign o_axi_arvalid = r_arvalid;
    assign o_axi_rready  = r_rready;

endmodule
